// File: rtl/game2048_pkg.sv
// Shared types, defaults and board-index helpers for the 2048 game core.
package game2048_pkg;

    localparam int unsigned N_DEF       = 4;
    localparam int unsigned EXP_W_DEF   = 4;
    localparam int unsigned WIN_EXP_DEF = 11;

    localparam logic [15:0] LFSR_SEED_DEF = 16'hACE1;
    // Feedback taps for x^16+x^14+x^13+x^11+1 on a left-shifting register.
    localparam logic [15:0] LFSR_TAPS     = 16'hB400;

    typedef enum logic [1:0] {
        DIR_UP    = 2'd0,
        DIR_DOWN  = 2'd1,
        DIR_LEFT  = 2'd2,
        DIR_RIGHT = 2'd3
    } dir_e;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START_SPAWN1,
        ST_START_SPAWN2,
        ST_WAIT,
        ST_MOVE,
        ST_SPAWN,
        ST_CHECK,
        ST_OVER
    } state_e;

    function automatic int unsigned cell_idx(input int unsigned r, input int unsigned c,
                                             input int unsigned n);
        return r * n + c;
    endfunction

    // Board cell feeding element j of line i, element 0 being the lead cell.
    function automatic int unsigned line_cell(input dir_e dir, input int unsigned i,
                                              input int unsigned j, input int unsigned n);
        int unsigned idx;
        case (dir)
            DIR_LEFT:  idx = cell_idx(i, j, n);
            DIR_RIGHT: idx = cell_idx(i, n - 1 - j, n);
            DIR_UP:    idx = cell_idx(j, i, n);
            default:   idx = cell_idx(n - 1 - j, i, n);
        endcase
        return idx;
    endfunction

endpackage

// File: rtl/game2048_engine_if.sv
// Control/status bundle between the button front end, the engine and the renderer.
interface game2048_engine_if
    import game2048_pkg::*;
#(
    parameter int unsigned N     = N_DEF,
    parameter int unsigned EXP_W = EXP_W_DEF
) ();

    logic                   start;
    logic                   move_valid;
    logic [1:0]             move_dir;
    logic                   move_ready;
    logic                   load_valid;
    logic [N*N*EXP_W-1:0]   load_board;
    logic                   spawn_en;
    logic [N*N*EXP_W-1:0]   board_flat;
    logic [31:0]            score;
    logic                   busy;
    logic                   game_over;
    logic                   win;

    modport master (
        output start, move_valid, move_dir, load_valid, load_board, spawn_en,
        input  move_ready, board_flat, score, busy, game_over, win
    );

    modport slave (
        input  start, move_valid, move_dir, load_valid, load_board, spawn_en,
        output move_ready, board_flat, score, busy, game_over, win
    );

endinterface

// File: rtl/game2048_line_merge.sv
// Combinational slide/merge of one line toward element 0.
module game2048_line_merge
    import game2048_pkg::*;
#(
    parameter int unsigned N     = N_DEF,
    parameter int unsigned EXP_W = EXP_W_DEF
) (
    input  logic [N-1:0][EXP_W-1:0]  line_in,
    output logic [N-1:0][EXP_W-1:0]  line_out,
    output logic [$clog2(N+1)-1:0]   merges,
    output logic [31:0]              score_inc,
    output logic                     changed
);

    localparam int unsigned PW = (N > 1) ? $clog2(N) : 1;
    localparam int unsigned CW = $clog2(N + 1);
    localparam int unsigned SW = EXP_W + 1;
    localparam logic [EXP_W-1:0] EMAX = '1;

    logic [EXP_W-1:0] pend;
    logic [PW-1:0]    pos;

    // Single pass: a held tile either pairs with the next non-zero tile or is emitted;
    // clearing it after a merge keeps the new tile from merging again.
    always_comb begin
        line_out  = '0;
        merges    = '0;
        score_inc = '0;
        pend      = '0;
        pos       = '0;
        for (int unsigned i = 0; i < N; i++) begin
            if (line_in[i] != '0) begin
                if (pend == line_in[i] && pend != EMAX) begin
                    line_out[pos] = pend + EXP_W'(1);
                    pos           = pos + PW'(1);
                    merges        = merges + CW'(1);
                    score_inc     = score_inc + (32'd1 << (SW'(pend) + SW'(1)));
                    pend          = '0;
                end else begin
                    if (pend != '0) begin
                        line_out[pos] = pend;
                        pos           = pos + PW'(1);
                    end
                    pend = line_in[i];
                end
            end
        end
        if (pend != '0) begin
            line_out[pos] = pend;
        end
        changed = (line_out != line_in);
    end

endmodule

// File: rtl/game2048_engine.sv
// 2048 game core: board, one-line-per-cycle moves, LFSR tile spawn, score/win/game-over.
module game2048_engine
    import game2048_pkg::*;
#(
    parameter int unsigned N       = N_DEF,
    parameter int unsigned EXP_W   = EXP_W_DEF,
    parameter int unsigned WIN_EXP = WIN_EXP_DEF,
    parameter logic [15:0] SEED    = LFSR_SEED_DEF
) (
    input  logic               SymClk,
    input  logic               Reset,
    game2048_engine_if.slave   bus
);

    localparam int unsigned CELLS = N * N;
    localparam int unsigned LW    = (N > 1) ? $clog2(N) : 1;
    localparam int unsigned CW    = $clog2(N + 1);
    localparam logic [EXP_W-1:0] EMAX  = '1;
    localparam logic [EXP_W-1:0] WIN_E = EXP_W'(WIN_EXP);
    localparam logic [15:0] SEED_EFF = (SEED == 16'h0000) ? LFSR_SEED_DEF : SEED;

    state_e                        state, state_nxt;
    logic [CELLS-1:0][EXP_W-1:0]   board;
    logic [31:0]                   score;
    logic [15:0]                   lfsr;
    dir_e                          dir_q;
    logic [LW-1:0]                 line_idx;
    logic                          moved;
    logic                          move_ready, busy, game_over, win;

    logic                          do_start, do_load, do_move, do_spawn;
    logic [N-1:0][EXP_W-1:0]       line_in, line_out;
    logic [CW-1:0]                 merges;
    logic [31:0]                   score_inc;
    logic                          line_changed;
    int unsigned                   spawn_base, spawn_idx;
    logic                          spawn_hit;
    logic [EXP_W-1:0]              spawn_exp;
    logic                          can_move, any_win;

    assign bus.board_flat = board;
    assign bus.score      = score;
    assign bus.move_ready = move_ready;
    assign bus.busy       = busy;
    assign bus.game_over  = game_over;
    assign bus.win        = win;

    // Gather the active line, lead cell first.
    always_comb begin
        line_in = '0;
        for (int unsigned j = 0; j < N; j++) begin
            line_in[j] = board[line_cell(dir_q, 32'(line_idx), j, N)];
        end
    end

    game2048_line_merge #(.N(N), .EXP_W(EXP_W)) u_merge (
        .line_in   (line_in),
        .line_out  (line_out),
        .merges    (merges),
        .score_inc (score_inc),
        .changed   (line_changed)
    );

    // First empty cell at or after the LFSR-chosen position, wrapping.
    always_comb begin
        spawn_base = 32'(lfsr[7:0]) % CELLS;
        spawn_idx  = 0;
        spawn_hit  = 1'b0;
        for (int unsigned k = 0; k < CELLS; k++) begin
            if (!spawn_hit && board[(spawn_base + k) % CELLS] == '0) begin
                spawn_hit = 1'b1;
                spawn_idx = (spawn_base + k) % CELLS;
            end
        end
        spawn_exp = (lfsr[15:12] == 4'h0) ? EXP_W'(2) : EXP_W'(1);
    end

    // Legal-move and win scan of the whole board.
    always_comb begin
        can_move = 1'b0;
        any_win  = 1'b0;
        for (int unsigned k = 0; k < CELLS; k++) begin
            if (board[k] == '0)    can_move = 1'b1;
            if (board[k] >= WIN_E) any_win  = 1'b1;
        end
        for (int unsigned r = 0; r < N; r++) begin
            for (int unsigned c = 0; c + 1 < N; c++) begin
                if (board[cell_idx(r, c, N)] == board[cell_idx(r, c + 1, N)] &&
                    board[cell_idx(r, c, N)] != EMAX) can_move = 1'b1;
            end
        end
        for (int unsigned r = 0; r + 1 < N; r++) begin
            for (int unsigned c = 0; c < N; c++) begin
                if (board[cell_idx(r, c, N)] == board[cell_idx(r + 1, c, N)] &&
                    board[cell_idx(r, c, N)] != EMAX) can_move = 1'b1;
            end
        end
    end

    always_ff @(posedge SymClk or posedge Reset) begin
        if (Reset) state <= ST_IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        do_start  = 1'b0;
        do_load   = 1'b0;
        do_move   = 1'b0;
        do_spawn  = 1'b0;
        case (state)
            ST_IDLE, ST_OVER: begin
                if (bus.start) begin
                    do_start  = 1'b1;
                    state_nxt = ST_START_SPAWN1;
                end
            end
            ST_START_SPAWN1: begin
                do_spawn  = bus.spawn_en;
                state_nxt = ST_START_SPAWN2;
            end
            ST_START_SPAWN2: begin
                do_spawn  = bus.spawn_en;
                state_nxt = ST_CHECK;
            end
            ST_WAIT: begin
                if (bus.start) begin
                    do_start  = 1'b1;
                    state_nxt = ST_START_SPAWN1;
                end else if (bus.load_valid) begin
                    do_load   = 1'b1;
                    state_nxt = ST_CHECK;
                end else if (bus.move_valid) begin
                    do_move   = 1'b1;
                    state_nxt = ST_MOVE;
                end
            end
            ST_MOVE: begin
                if (line_idx == LW'(N - 1)) state_nxt = ST_SPAWN;
            end
            ST_SPAWN: begin
                do_spawn  = moved & bus.spawn_en;
                state_nxt = ST_CHECK;
            end
            ST_CHECK: state_nxt = can_move ? ST_WAIT : ST_OVER;
            default:  state_nxt = ST_IDLE;
        endcase
    end

    // Datapath; status flags are registered from the next state so they flip on the same edge.
    always_ff @(posedge SymClk or posedge Reset) begin
        if (Reset) begin
            board      <= '0;
            score      <= '0;
            lfsr       <= SEED_EFF;
            dir_q      <= DIR_UP;
            line_idx   <= '0;
            moved      <= 1'b0;
            move_ready <= 1'b0;
            busy       <= 1'b0;
            game_over  <= 1'b0;
            win        <= 1'b0;
        end else begin
            lfsr       <= {lfsr[14:0], ^(lfsr & LFSR_TAPS)};
            move_ready <= (state_nxt == ST_WAIT);
            busy       <= (state_nxt == ST_MOVE) || (state_nxt == ST_SPAWN) ||
                          (state_nxt == ST_CHECK);
            if (do_start) begin
                board     <= '0;
                score     <= '0;
                win       <= 1'b0;
                game_over <= 1'b0;
            end
            if (do_load) board <= bus.load_board;
            if (do_move) begin
                dir_q    <= dir_e'(bus.move_dir);
                line_idx <= '0;
                moved    <= 1'b0;
            end
            if (state == ST_MOVE) begin
                for (int unsigned j = 0; j < N; j++) begin
                    board[line_cell(dir_q, 32'(line_idx), j, N)] <= line_out[j];
                end
                if (merges != '0) score <= score + score_inc;
                moved    <= moved | line_changed;
                line_idx <= line_idx + LW'(1);
            end
            if (do_spawn && spawn_hit) board[spawn_idx] <= spawn_exp;
            if (state == ST_CHECK) begin
                win       <= win | any_win;
                game_over <= ~can_move;
            end
        end
    end

endmodule

// File: tb/tb_game2048_engine.sv
// Directed-vector bench for game2048_engine with hand-computed boards and scores.
module tb_game2048_engine;
    import game2048_pkg::*;

    localparam int unsigned N     = 4;
    localparam int unsigned EXP_W = 4;
    localparam int unsigned CELLS = N * N;
    localparam int unsigned BW    = CELLS * EXP_W;

    logic SymClk = 1'b0;
    logic Reset  = 1'b1;

    game2048_engine_if #(.N(N), .EXP_W(EXP_W)) bus ();

    game2048_engine #(.N(N), .EXP_W(EXP_W), .WIN_EXP(11), .SEED(16'hACE1)) dut (
        .SymClk (SymClk),
        .Reset  (Reset),
        .bus    (bus)
    );

    always #5 SymClk = ~SymClk;

    int total = 0;
    int bad   = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge SymClk);
        #1;
    endtask

    task automatic wait_ready(output int cyc);
        cyc = 0;
        while (!bus.move_ready && cyc < 40) begin
            tick();
            cyc++;
        end
    endtask

    task automatic new_game(output int cyc);
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        wait_ready(cyc);
    endtask

    task automatic do_load(input logic [BW-1:0] b);
        bus.load_valid = 1'b1;
        bus.load_board = b;
        tick();
        bus.load_valid = 1'b0;
        bus.load_board = '0;
        tick();
    endtask

    // Direction is scrambled right after acceptance; the engine must keep the latched one.
    task automatic do_move(input string tag, input logic [1:0] dir, output int cyc);
        bus.move_valid = 1'b1;
        bus.move_dir   = dir;
        tick();
        bus.move_valid = 1'b0;
        bus.move_dir   = ~dir;
        check(tag, {62'd0, bus.busy, bus.move_ready}, 64'b10);
        wait_ready(cyc);
    endtask

    function automatic logic [BW-1:0] put(input logic [BW-1:0] b, input int r, input int c,
                                          input logic [EXP_W-1:0] v);
        b[(r * N + c) * EXP_W +: EXP_W] = v;
        return b;
    endfunction

    initial begin
        #100000;
        $display("FAIL watchdog total=%0d bad=%0d", total, bad);
        $fatal(1);
    end

    initial begin
        logic [BW-1:0] b, e;
        logic [EXP_W-1:0] v;
        int cyc, nz, ok;

        bus.start      = 1'b0;
        bus.move_valid = 1'b0;
        bus.move_dir   = 2'd0;
        bus.load_valid = 1'b0;
        bus.load_board = '0;
        bus.spawn_en   = 1'b0;

        repeat (3) tick();
        check("rst_board", 64'(bus.board_flat), 64'd0);
        check("rst_score", 64'(bus.score), 64'd0);
        check("rst_ready", 64'(bus.move_ready), 64'd0);
        check("rst_busy",  64'(bus.busy), 64'd0);
        check("rst_over",  64'(bus.game_over), 64'd0);
        check("rst_win",   64'(bus.win), 64'd0);
        check("rst_lfsr",  64'(dut.lfsr), 64'hACE1);
        Reset = 1'b0;
        tick();
        check("lfsr_step", 64'(dut.lfsr), 64'h59C3);
        tick();
        check("idle_ready", 64'(bus.move_ready), 64'd0);

        // Start with spawning: two tiles of exponent 1 or 2, ready three edges later.
        bus.spawn_en = 1'b1;
        new_game(cyc);
        check("start_lat", 64'(cyc), 64'd3);
        nz = 0;
        ok = 0;
        for (int k = 0; k < int'(CELLS); k++) begin
            v = bus.board_flat[k * EXP_W +: EXP_W];
            if (v != '0) nz++;
            if (v == 4'd1 || v == 4'd2) ok++;
        end
        check("start_tiles", 64'(nz), 64'd2);
        check("start_vals",  64'(ok), 64'd2);
        bus.spawn_en = 1'b0;

        // Row of four equal tiles merges pairwise.
        new_game(cyc);
        check("clr_score", 64'(bus.score), 64'd0);
        b = '0;
        for (int c = 0; c < 4; c++) b = put(b, 0, c, 4'd1);
        do_load(b);
        check("pairs_load", 64'(bus.board_flat), 64'(b));
        do_move("pairs_hs", DIR_LEFT, cyc);
        e = '0;
        e = put(e, 0, 0, 4'd2);
        e = put(e, 0, 1, 4'd2);
        check("pairs_board", 64'(bus.board_flat), 64'(e));
        check("pairs_score", 64'(bus.score), 64'd8);
        check("pairs_lat",   64'(cyc), 64'd6);

        // Three equal tiles: lead pair merges, third stays.
        new_game(cyc);
        b = '0;
        for (int c = 0; c < 3; c++) b = put(b, 0, c, 4'd1);
        do_load(b);
        do_move("tri_hs", DIR_RIGHT, cyc);
        e = '0;
        e = put(e, 0, 2, 4'd1);
        e = put(e, 0, 3, 4'd2);
        check("tri_board", 64'(bus.board_flat), 64'(e));
        check("tri_score", 64'(bus.score), 64'd4);

        // Column moved down: new tile must not re-merge with its equal neighbour.
        new_game(cyc);
        b = '0;
        b = put(b, 0, 1, 4'd1);
        b = put(b, 2, 1, 4'd1);
        b = put(b, 3, 1, 4'd2);
        do_load(b);
        do_move("down_hs", DIR_DOWN, cyc);
        e = '0;
        e = put(e, 2, 1, 4'd2);
        e = put(e, 3, 1, 4'd2);
        check("down_board", 64'(bus.board_flat), 64'(e));
        check("down_score", 64'(bus.score), 64'd4);

        // Move that changes nothing must not spawn even with spawning on.
        new_game(cyc);
        b = put('0, 0, 0, 4'd3);
        do_load(b);
        bus.spawn_en = 1'b1;
        do_move("noop_hs", DIR_LEFT, cyc);
        bus.spawn_en = 1'b0;
        check("noop_board", 64'(bus.board_flat), 64'(b));
        check("noop_score", 64'(bus.score), 64'd0);
        check("noop_lat",   64'(cyc), 64'd6);

        // Two 1024s merge upward into 2048.
        new_game(cyc);
        b = '0;
        b = put(b, 0, 0, 4'd10);
        b = put(b, 1, 0, 4'd10);
        do_load(b);
        check("win_pre", 64'(bus.win), 64'd0);
        do_move("win_hs", DIR_UP, cyc);
        check("win_board", 64'(bus.board_flat), 64'(put('0, 0, 0, 4'd11)));
        check("win_flag",  64'(bus.win), 64'd1);
        check("win_score", 64'(bus.score), 64'd2048);

        // Adjacent EMAX tiles never merge.
        new_game(cyc);
        check("win_clr", 64'(bus.win), 64'd0);
        b = '0;
        b = put(b, 0, 0, 4'd15);
        b = put(b, 0, 1, 4'd15);
        do_load(b);
        do_move("emax_hs", DIR_LEFT, cyc);
        check("emax_left", 64'(bus.board_flat), 64'(b));
        do_move("emax_hs2", DIR_RIGHT, cyc);
        e = '0;
        e = put(e, 0, 2, 4'd15);
        e = put(e, 0, 3, 4'd15);
        check("emax_right", 64'(bus.board_flat), 64'(e));
        check("emax_score", 64'(bus.score), 64'd0);

        // Checkerboard of 1/2 has no legal move.
        new_game(cyc);
        b = '0;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                b = put(b, r, c, ((r + c) % 2 == 1) ? 4'd2 : 4'd1);
        do_load(b);
        check("over_flag",  64'(bus.game_over), 64'd1);
        check("over_ready", 64'(bus.move_ready), 64'd0);
        bus.move_valid = 1'b1;
        bus.move_dir   = DIR_LEFT;
        repeat (4) tick();
        bus.move_valid = 1'b0;
        check("over_busy", 64'(bus.busy), 64'd0);
        bus.load_valid = 1'b1;
        tick();
        bus.load_valid = 1'b0;
        tick();
        check("over_hold", 64'(bus.board_flat), 64'(b));
        new_game(cyc);
        check("over_restart", 64'(cyc), 64'd3);
        check("over_clr",     64'(bus.game_over), 64'd0);
        check("over_board",   64'(bus.board_flat), 64'd0);

        // Partial board visible mid-move, then reset aborts the move.
        b = '0;
        b = put(b, 0, 0, 4'd1);
        b = put(b, 0, 1, 4'd1);
        do_load(b);
        bus.move_valid = 1'b1;
        bus.move_dir   = DIR_LEFT;
        tick();
        bus.move_valid = 1'b0;
        tick();
        check("mid_board", 64'(bus.board_flat), 64'(put('0, 0, 0, 4'd2)));
        check("mid_score", 64'(bus.score), 64'd4);
        Reset = 1'b1;
        #1;
        check("abort_board", 64'(bus.board_flat), 64'd0);
        check("abort_score", 64'(bus.score), 64'd0);
        check("abort_busy",  64'(bus.busy), 64'd0);
        tick();
        Reset = 1'b0;
        repeat (3) tick();
        check("abort_idle", 64'({bus.busy, bus.move_ready}), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/game2048_engine.md
# game2048_engine

Parametrised 2048 game core: holds an N×N board of tile exponents and executes all four slide/merge moves one line per clock. It spawns random tiles from a free-running LFSR, and tracks score, win and game-over. It sits between the button-decode/debounce front end and the VGA renderer, which reads `board_flat` directly.

## Interface
Parameters:
- `N`, 4: board side; cells = N*N.
- `EXP_W`, 4: tile exponent width; 0 = empty, k = tile value 2^k; max exponent EMAX = 2^EXP_W−1.
- `WIN_EXP`, 11: exponent that sets `win` (2048).
- `SEED`, 16'hACE1: LFSR reset value; a value of 0 is replaced by 16'hACE1.

Ports:
- `SymClk` in 1: clock.
- `Reset` in 1: asynchronous, active-high.
- `start` in 1: new game; clears board and score, then spawns two tiles.
- `move_valid` in 1: move request.
- `move_dir` in 2: 0 up, 1 down, 2 left, 3 right.
- `move_ready` out 1: engine can accept a move.
- `load_valid` in 1: test/debug board load; accepted only when `move_ready`=1.
- `load_board` in N*N*EXP_W: board to load.
- `spawn_en` in 1: 0 suppresses all spawns, including the start spawns.
- `board_flat` out N*N*EXP_W: cell (r,c) at bits [(r*N+c)*EXP_W +: EXP_W], row 0 at top.
- `score` out 32: sum of merged tile values, wraps mod 2^32.
- `busy` out 1: high in MOVE/SPAWN/CHECK.
- `game_over` out 1: no legal move remains.
- `win` out 1: sticky once any cell ≥ WIN_EXP; cleared by start/Reset.

## Operation
- Reset values: board all 0, `score`=0, `move_ready`=0, `busy`=0, `game_over`=0, `win`=0, LFSR=SEED, state IDLE.
- LFSR: 16-bit Fibonacci, taps x^16+x^14+x^13+x^11+1. Advances every cycle when not in reset.
- States:
  - IDLE: wait for `start`.
  - START_SPAWN ×2: two spawns.
  - WAIT: `move_ready`=1.
  - MOVE: N cycles, one line per cycle.
  - SPAWN
  - CHECK
  - OVER: `move_ready`=0; only `start` exits.
- `start` is honoured in IDLE, WAIT and OVER. It is ignored in MOVE/SPAWN/CHECK.
- Priority in WAIT: `start` > `load_valid` > `move_valid`.
- Load: the board is replaced and `score` is unchanged. The engine then goes to CHECK with no spawn.
- Line extraction for line i:
  - left: row i, lead c=0.
  - right: row i, lead c=N−1.
  - up: column i, lead r=0.
  - down: column i, lead r=N−1.
- Line rule, from the lead:
  1. Compress non-zero cells.
  2. Merge each adjacent equal pair once, exponent+1. A tile produced by a merge does not merge again in the same move. Pairs at EMAX do not merge.
  3. Compress again.
  4. Score += 2^(e+1) per merge.
- `changed` = any line differs from its input. SPAWN runs only if `changed` and `spawn_en`=1.
- Spawn target:
  - p = LFSR[7:0] mod N*N.
  - Choose the first empty cell at index ≥p, wrapping to 0.
  - Exponent is 2 if LFSR[15:12]==0, else 1.
  - No empty cell → no write.
- CHECK:
  - `game_over`=1 and go to OVER iff no empty cell and no horizontally or vertically adjacent equal pair below EMAX. Otherwise go to WAIT.
  - `win` is updated in CHECK.

## Timing
- Move accepted at edge T (`move_valid`&&`move_ready`). `move_ready` falls and `busy` rises at T.
- Line i is written at edge T+1+i, so partial boards are visible on `board_flat` during the move.
- Spawn is written at T+N+1. CHECK completes at T+N+2, raising `move_ready` (or `game_over`).
- Score updates per line with its line write.
- `start` → spawn 1 at +1, spawn 2 at +2, CHECK at +3. `move_ready` is high after +3.
- `move_dir` is sampled only at acceptance. Later changes do not affect the move in progress.
- Reset asserted mid-move aborts immediately to reset values. There is no partial completion.

## Structure
- Shared `game2048_pkg`:
  - direction encodings
  - state encoding
  - LFSR taps and default SEED
  - cell-index helper function
  - default N/EXP_W/WIN_EXP
- Sub-module `game2048_line_merge`: combinational; N×EXP_W line in → line out, merge count and score increment, `changed`. Instantiated once and reused each MOVE cycle.

## Test plan
- Reset:
  - Stimulus: Reset pulse.
  - Required: all outputs at their reset values; LFSR=16'hACE1.
  - Then `start` with `spawn_en`=1: exactly 2 non-zero cells, each of value 1 or 2; `move_ready` high after 3 cycles.
- Merge pairs (`spawn_en`=0):
  - Stimulus: load row0=[1,1,1,1], rest 0; move left.
  - Required: row0=[2,2,0,0]; `score`=8; `move_ready` back after N+2 cycles.
- Triple (`spawn_en`=0):
  - Stimulus: load row0=[1,1,1,0]; move right.
  - Required: row0=[0,0,1,2]; `score`=4.
- No-op move with spawn enabled:
  - Stimulus: load only (0,0)=3; move left, `spawn_en`=1.
  - Required: board unchanged; no spawn; `score` unchanged.
- Game over:
  - Stimulus: load a checkerboard of exponents 1/2.
  - Required: CHECK sets `game_over`=1, `move_ready`=0; subsequent moves are ignored until `start`.
- Win and EMAX:
  - Stimulus: load col0=[10,10,0,0]; move up.
  - Required: (0,0)=11; `win`=1; `score`=2048.
  - Stimulus: load two EMAX cells adjacent; move toward each other.
  - Required: no merge.
